// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the shared memory port and the arbiter.
// The "slave" modport is the arbiter's view; "master" is the requester/memory side.
interface mem_port_arbiter_if;
  logic        CpuReq;
  logic        CpuWe;
  logic [15:0] CpuAddr;
  logic [15:0] CpuWData;
  logic        CpuGnt;
  logic        CpuRValid;
  logic        CpuStall;
  logic [15:0] CpuRData;

  logic        DmaReq;
  logic        DmaWe;
  logic        DmaLock;
  logic [15:0] DmaAddr;
  logic [15:0] DmaWData;
  logic        DmaGnt;
  logic        DmaRValid;
  logic [15:0] DmaRData;

  logic [15:0] MemAddr;
  logic [15:0] MemWData;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] MemRData;

  modport slave (
    input  CpuReq, CpuWe, CpuAddr, CpuWData,
    input  DmaReq, DmaWe, DmaLock, DmaAddr, DmaWData,
    input  MemRData,
    output CpuGnt, CpuRValid, CpuStall, CpuRData,
    output DmaGnt, DmaRValid, DmaRData,
    output MemAddr, MemWData, MemRead, MemWrite
  );

  modport master (
    output CpuReq, CpuWe, CpuAddr, CpuWData,
    output DmaReq, DmaWe, DmaLock, DmaAddr, DmaWData,
    output MemRData,
    input  CpuGnt, CpuRValid, CpuStall, CpuRData,
    input  DmaGnt, DmaRValid, DmaRData,
    input  MemAddr, MemWData, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single memory port with CPU priority,
// DMA starvation escape and bounded DMA lock bursts.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input logic               CLK,
  input logic               CtrlRstN,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            cpu_rvalid_q, cpu_rvalid_d;
  logic            dma_rvalid_q, dma_rvalid_d;

  logic            cpu_gnt, dma_gnt;
  logic            cpu_live, dma_live, lock_hold;
  logic            cpu_rd, cpu_wr, dma_rd, dma_wr;

  function automatic logic [SW-1:0] starve_sat_inc(input logic [SW-1:0] v);
    return (v >= STARVE_TOP) ? STARVE_TOP : v + SW'(1);
  endfunction

  function automatic logic [BW-1:0] burst_sat_inc(input logic [BW-1:0] v);
    return (v >= BURST_TOP) ? BURST_TOP : v + BW'(1);
  endfunction

  assign cpu_gnt = (state_q == ST_CPU);
  assign dma_gnt = (state_q == ST_DMA);

  assign cpu_rd = cpu_gnt & bus.CpuReq & ~bus.CpuWe;
  assign cpu_wr = cpu_gnt & bus.CpuReq &  bus.CpuWe;
  assign dma_rd = dma_gnt & bus.DmaReq & ~bus.DmaWe;
  assign dma_wr = dma_gnt & bus.DmaReq &  bus.DmaWe;

  // A requester granted this cycle has its request consumed by this cycle's access.
  assign cpu_live  = bus.CpuReq & ~cpu_gnt;
  assign dma_live  = bus.DmaReq & ~dma_gnt;
  assign lock_hold = dma_gnt & bus.DmaLock & (burst_q < BURST_TOP);

  always_comb begin
    state_d  = ST_IDLE;
    burst_d  = '0;
    starve_d = '0;

    if (lock_hold) begin
      state_d = ST_DMA;
    end else if (dma_live && (starve_q >= STARVE_TOP)) begin
      state_d = ST_DMA;
    end else if (cpu_live) begin
      state_d = ST_CPU;
    end else if (dma_live) begin
      state_d = ST_DMA;
    end

    // Only the lock rule can keep DMA granted, so staying in DMA means a continuation.
    if (state_d == ST_DMA) begin
      burst_d = dma_gnt ? burst_sat_inc(burst_q) : BW'(1);
    end

    if (bus.DmaReq && !dma_gnt) begin
      starve_d = starve_sat_inc(starve_q);
    end

    cpu_rvalid_d = cpu_rd;
    dma_rvalid_d = dma_rd;
  end

  always_ff @(posedge CLK) begin
    if (!CtrlRstN) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      burst_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      burst_q      <= burst_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  // Memory port: address/data follow the grant holder, strobes only on a real access.
  always_comb begin
    bus.MemAddr  = '0;
    bus.MemWData = '0;
    if (cpu_gnt) begin
      bus.MemAddr  = bus.CpuAddr;
      bus.MemWData = bus.CpuWData;
    end else if (dma_gnt) begin
      bus.MemAddr  = bus.DmaAddr;
      bus.MemWData = bus.DmaWData;
    end
  end

  assign bus.MemRead  = cpu_rd | dma_rd;
  assign bus.MemWrite = cpu_wr | dma_wr;

  assign bus.CpuGnt    = cpu_gnt;
  assign bus.DmaGnt    = dma_gnt;
  assign bus.CpuStall  = bus.CpuReq & ~cpu_gnt;
  assign bus.CpuRValid = cpu_rvalid_q;
  assign bus.DmaRValid = dma_rvalid_q;
  assign bus.CpuRData  = bus.MemRData;
  assign bus.DmaRData  = bus.MemRData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a rule-level model.
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int BURST_MAX    = 8;

  logic CLK = 1'b0;
  logic CtrlRstN;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)) dut (
    .CLK(CLK), .CtrlRstN(CtrlRstN), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner 0 = nobody, 1 = CPU, 2 = DMA
  int m_owner = 0;
  int m_starve = 0;
  int m_burst = 0;
  bit m_cpu_rv = 0;
  bit m_dma_rv = 0;

  function automatic void model_edge();
    int nxt;
    bit cpu_live, dma_live;
    if (!CtrlRstN) begin
      m_owner = 0; m_starve = 0; m_burst = 0; m_cpu_rv = 0; m_dma_rv = 0;
      return;
    end
    cpu_live = bus.CpuReq && (m_owner != 1);
    dma_live = bus.DmaReq && (m_owner != 2);
    m_cpu_rv = (m_owner == 1) && bus.CpuReq && !bus.CpuWe;
    m_dma_rv = (m_owner == 2) && bus.DmaReq && !bus.DmaWe;
    if (m_owner == 2 && bus.DmaLock && m_burst < BURST_MAX) nxt = 2;
    else if (dma_live && m_starve >= STARVE_LIMIT)          nxt = 2;
    else if (cpu_live)                                     nxt = 1;
    else if (dma_live)                                     nxt = 2;
    else                                                   nxt = 0;
    if (bus.DmaReq && m_owner != 2) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
    else                            m_starve = 0;
    if (nxt != 2)          m_burst = 0;
    else if (m_owner == 2) m_burst = m_burst + 1;
    else                   m_burst = 1;
    m_owner = nxt;
  endfunction

  task automatic advance();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CpuReq = 0; bus.CpuWe = 0; bus.CpuAddr = '0; bus.CpuWData = '0;
    bus.DmaReq = 0; bus.DmaWe = 0; bus.DmaLock = 0; bus.DmaAddr = '0; bus.DmaWData = '0;
    bus.MemRData = '0;
  endtask

  task automatic test_reset();
    CtrlRstN = 1'b0;
    idle_inputs();
    bus.CpuReq = 1;
    advance();
    advance();
    @(negedge CLK);
    n_cmp++; if (bus.CpuGnt !== 1'b0)    begin n_bad++; $display("FAIL rst_cpu_gnt got %b want 0", bus.CpuGnt); end
    n_cmp++; if (bus.DmaGnt !== 1'b0)    begin n_bad++; $display("FAIL rst_dma_gnt got %b want 0", bus.DmaGnt); end
    n_cmp++; if (bus.CpuRValid !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_rvalid got %b want 0", bus.CpuRValid); end
    n_cmp++; if (bus.DmaRValid !== 1'b0) begin n_bad++; $display("FAIL rst_dma_rvalid got %b want 0", bus.DmaRValid); end
    n_cmp++; if (bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0) begin n_bad++; $display("FAIL rst_mem_strobe got %b%b want 00", bus.MemRead, bus.MemWrite); end
    n_cmp++; if (bus.MemAddr !== 16'h0) begin n_bad++; $display("FAIL rst_mem_addr got %h want 0000", bus.MemAddr); end
    n_cmp++; if (bus.CpuStall !== 1'b1)  begin n_bad++; $display("FAIL rst_cpu_stall got %b want 1", bus.CpuStall); end
    bus.CpuReq = 0;
    CtrlRstN = 1'b1;
    advance();
  endtask

  task automatic test_cpu_read();
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 16'h0040;
    @(negedge CLK);
    n_cmp++; if (bus.CpuGnt !== 1'b0 || bus.CpuStall !== 1'b1) begin n_bad++; $display("FAIL cpurd_c0 gnt/stall got %b/%b want 0/1", bus.CpuGnt, bus.CpuStall); end
    advance();
    @(negedge CLK);
    n_cmp++; if (bus.CpuGnt !== 1'b1)    begin n_bad++; $display("FAIL cpurd_gnt got %b want 1", bus.CpuGnt); end
    n_cmp++; if (bus.MemRead !== 1'b1 || bus.MemWrite !== 1'b0) begin n_bad++; $display("FAIL cpurd_strobe got rd%b wr%b want rd1 wr0", bus.MemRead, bus.MemWrite); end
    n_cmp++; if (bus.MemAddr !== 16'h0040) begin n_bad++; $display("FAIL cpurd_addr got %h want 0040", bus.MemAddr); end
    advance();
    bus.CpuReq = 0; bus.MemRData = 16'hA5C3;
    @(negedge CLK);
    n_cmp++; if (bus.CpuRValid !== 1'b1) begin n_bad++; $display("FAIL cpurd_rvalid got %b want 1", bus.CpuRValid); end
    n_cmp++; if (bus.CpuRData !== 16'hA5C3) begin n_bad++; $display("FAIL cpurd_rdata got %h want a5c3", bus.CpuRData); end
    n_cmp++; if (bus.CpuGnt !== 1'b0)    begin n_bad++; $display("FAIL cpurd_regrant got %b want 0", bus.CpuGnt); end
    advance();
    @(negedge CLK);
    n_cmp++; if (bus.CpuRValid !== 1'b0) begin n_bad++; $display("FAIL cpurd_rvalid_pulse got %b want 0", bus.CpuRValid); end
    advance();
  endtask

  task automatic test_contention();
    int first = 0;
    int dma_at = -1;
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 16'h0100;
    bus.DmaReq = 1; bus.DmaWe = 0; bus.DmaAddr = 16'h0200;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (first == 0 && bus.CpuGnt)  first = 1;
      if (first == 0 && bus.DmaGnt)  first = 2;
      if (dma_at < 0 && bus.DmaGnt)  dma_at = c;
      n_cmp++; if (bus.DmaGnt !== (m_owner == 2)) begin n_bad++; $display("FAIL cont_dma_gnt c%0d got %b want %b", c, bus.DmaGnt, m_owner == 2); end
      advance();
    end
    n_cmp++; if (first != 1) begin n_bad++; $display("FAIL cont_first_winner got %0d want 1 (cpu)", first); end
    n_cmp++; if (dma_at < 1 || dma_at > 5) begin n_bad++; $display("FAIL cont_dma_latency got cycle %0d want 1..5", dma_at); end
    idle_inputs();
    advance(); advance();
  endtask

  task automatic test_burst();
    int run = 0;
    bit done = 0;
    bus.DmaReq = 1; bus.DmaLock = 1; bus.DmaWe = 0; bus.DmaAddr = 16'h0300;
    bus.CpuWe = 1; bus.CpuAddr = 16'h0400; bus.CpuWData = 16'h1111;
    for (int c = 0; c < 14; c++) begin
      if (c == 1)  bus.CpuReq = 1;
      if (c == 12) bus.DmaReq = 0;
      @(negedge CLK);
      if (bus.DmaGnt && !done) begin
        run++;
        n_cmp++; if (bus.CpuStall !== 1'b1 && c >= 1) begin n_bad++; $display("FAIL burst_stall c%0d got %b want 1", c, bus.CpuStall); end
      end else if (run > 0 && !done) begin
        done = 1;
        n_cmp++; if (run != BURST_MAX) begin n_bad++; $display("FAIL burst_len got %0d want %0d", run, BURST_MAX); end
        n_cmp++; if (bus.CpuGnt !== 1'b1) begin n_bad++; $display("FAIL burst_cpu_after got %b want 1", bus.CpuGnt); end
      end
      advance();
    end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL burst_timeout got run %0d want end after %0d", run, BURST_MAX); end
    idle_inputs();
    advance(); advance(); advance();
  endtask

  task automatic test_dma_write();
    bus.DmaReq = 1; bus.DmaWe = 1; bus.DmaLock = 0; bus.DmaAddr = 16'h1234; bus.DmaWData = 16'hBEEF;
    @(negedge CLK);
    n_cmp++; if (bus.MemWrite !== 1'b0 || bus.DmaGnt !== 1'b0) begin n_bad++; $display("FAIL dmawr_c0 wr/gnt got %b/%b want 0/0", bus.MemWrite, bus.DmaGnt); end
    advance();
    @(negedge CLK);
    n_cmp++; if (bus.DmaGnt !== 1'b1 || bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0) begin n_bad++; $display("FAIL dmawr_grant gnt/wr/rd got %b/%b/%b want 1/1/0", bus.DmaGnt, bus.MemWrite, bus.MemRead); end
    n_cmp++; if (bus.MemAddr !== 16'h1234 || bus.MemWData !== 16'hBEEF) begin n_bad++; $display("FAIL dmawr_data got %h/%h want 1234/beef", bus.MemAddr, bus.MemWData); end
    advance();
    bus.DmaReq = 0;
    @(negedge CLK);
    n_cmp++; if (bus.MemWrite !== 1'b0 || bus.DmaRValid !== 1'b0) begin n_bad++; $display("FAIL dmawr_after wr/rv got %b/%b want 0/0", bus.MemWrite, bus.DmaRValid); end
    advance();
    @(negedge CLK);
    n_cmp++; if (bus.DmaRValid !== 1'b0) begin n_bad++; $display("FAIL dmawr_rvalid got %b want 0", bus.DmaRValid); end
    advance();
  endtask

  task automatic test_reset_mid_burst();
    int beats = 0;
    bus.DmaReq = 1; bus.DmaWe = 0; bus.DmaLock = 1; bus.DmaAddr = 16'h0500;
    for (int c = 0; c < 8 && beats < 3; c++) begin
      @(negedge CLK);
      if (bus.DmaGnt) beats++;
      if (beats == 3) CtrlRstN = 1'b0;
      advance();
    end
    if (beats < 3) begin n_cmp++; n_bad++; $display("FAIL rstburst_timeout got %0d beats want 3", beats); CtrlRstN = 1'b0; advance(); end
    CtrlRstN = 1'b1; bus.DmaReq = 0; bus.DmaLock = 0;
    @(negedge CLK);
    n_cmp++; if (bus.DmaGnt !== 1'b0 || bus.CpuGnt !== 1'b0) begin n_bad++; $display("FAIL rstburst_gnt got %b%b want 00", bus.CpuGnt, bus.DmaGnt); end
    n_cmp++; if (bus.DmaRValid !== 1'b0 || bus.CpuRValid !== 1'b0) begin n_bad++; $display("FAIL rstburst_rvalid got %b%b want 00", bus.CpuRValid, bus.DmaRValid); end
    n_cmp++; if (bus.MemRead !== 1'b0 || bus.MemAddr !== 16'h0) begin n_bad++; $display("FAIL rstburst_mem got rd%b addr %h want rd0 addr 0000", bus.MemRead, bus.MemAddr); end
    advance();
    bus.DmaReq = 1;
    @(negedge CLK);
    n_cmp++; if (bus.DmaGnt !== 1'b0) begin n_bad++; $display("FAIL rstburst_req_c0 got %b want 0", bus.DmaGnt); end
    advance();
    @(negedge CLK);
    n_cmp++; if (bus.DmaGnt !== 1'b1) begin n_bad++; $display("FAIL rstburst_regrant got %b want 1", bus.DmaGnt); end
    advance();
    idle_inputs();
    advance(); advance();
  endtask

  task automatic test_random();
    bit cpu_pend = 0, dma_pend = 0;
    bit e_cg, e_dg, e_rd, e_wr;
    logic [15:0] e_addr, e_wd;
    for (int i = 0; i < 3000; i++) begin
      if (!cpu_pend) begin
        bus.CpuReq = ($urandom_range(0, 99) < 40); bus.CpuWe = 1'($urandom_range(0, 1));
        bus.CpuAddr = 16'($urandom); bus.CpuWData = 16'($urandom);
      end
      if (!dma_pend) begin
        bus.DmaReq = ($urandom_range(0, 99) < 45); bus.DmaWe = 1'($urandom_range(0, 1));
        bus.DmaAddr = 16'($urandom); bus.DmaWData = 16'($urandom);
      end
      if ($urandom_range(0, 99) < 10) bus.DmaLock = ~bus.DmaLock;
      CtrlRstN = ($urandom_range(0, 199) != 0);
      bus.MemRData = 16'($urandom);
      @(negedge CLK);
      e_cg = (m_owner == 1);
      e_dg = (m_owner == 2);
      e_rd = (e_cg && bus.CpuReq && !bus.CpuWe) || (e_dg && bus.DmaReq && !bus.DmaWe);
      e_wr = (e_cg && bus.CpuReq && bus.CpuWe)  || (e_dg && bus.DmaReq && bus.DmaWe);
      e_addr = e_cg ? bus.CpuAddr : bus.DmaAddr;
      e_wd   = e_cg ? bus.CpuWData : bus.DmaWData;
      n_cmp++; if (bus.CpuGnt !== e_cg) begin n_bad++; $display("FAIL rnd_cpu_gnt i%0d got %b want %b", i, bus.CpuGnt, e_cg); end
      n_cmp++; if (bus.DmaGnt !== e_dg) begin n_bad++; $display("FAIL rnd_dma_gnt i%0d got %b want %b", i, bus.DmaGnt, e_dg); end
      n_cmp++; if (bus.MemRead !== e_rd || bus.MemWrite !== e_wr) begin n_bad++; $display("FAIL rnd_strobe i%0d got rd%b wr%b want rd%b wr%b", i, bus.MemRead, bus.MemWrite, e_rd, e_wr); end
      if (e_rd || e_wr) begin
        n_cmp++; if (bus.MemAddr !== e_addr || bus.MemWData !== e_wd) begin n_bad++; $display("FAIL rnd_mem_bus i%0d got %h/%h want %h/%h", i, bus.MemAddr, bus.MemWData, e_addr, e_wd); end
      end
      n_cmp++; if (bus.CpuStall !== (bus.CpuReq && !e_cg)) begin n_bad++; $display("FAIL rnd_stall i%0d got %b want %b", i, bus.CpuStall, bus.CpuReq && !e_cg); end
      n_cmp++; if (bus.CpuRValid !== m_cpu_rv || bus.DmaRValid !== m_dma_rv) begin n_bad++; $display("FAIL rnd_rvalid i%0d got %b%b want %b%b", i, bus.CpuRValid, bus.DmaRValid, m_cpu_rv, m_dma_rv); end
      n_cmp++; if (bus.CpuRData !== bus.MemRData || bus.DmaRData !== bus.MemRData) begin n_bad++; $display("FAIL rnd_rdata i%0d got %h/%h want %h", i, bus.CpuRData, bus.DmaRData, bus.MemRData); end
      cpu_pend = bus.CpuReq && !e_cg;
      dma_pend = bus.DmaReq && !e_dg;
      advance();
    end
    CtrlRstN = 1'b1;
    idle_inputs();
    advance(); advance(); advance();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_contention();
    test_burst();
    test_dma_write();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
